// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Results and the divide-by-zero flag are registered and held until the next done or reset.
module serial_divider #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CNT_W = $clog2(DIVIDEND_W);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
   logic [DIVISOR_W-1:0]    rem_q, rem_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
   logic                    dbz_q, dbz_d;
   logic [DIVISOR_W:0]      shift_s;
   logic [DIVISOR_W:0]      diff_s;

   // Next-state, datapath iteration and output update logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      // rem_q < divisor always, so the trial difference fits in DIVISOR_W+1 bits and its MSB is the borrow.
      shift_s = {rem_q, dvd_q[DIVIDEND_W-1]};
      diff_s  = shift_s - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == {DIVISOR_W{1'b0}}) begin
                  done_d      = 1'b1;
                  quotient_d  = {DIVIDEND_W{1'b1}};
                  remainder_d = {DIVISOR_W{1'b1}};
                  dbz_d       = 1'b1;
               end else begin
                  state_d = CALC;
                  busy_d  = 1'b1;
                  cnt_d   = {CNT_W{1'b0}};
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  rem_d   = {DIVISOR_W{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (diff_s[DIVISOR_W]) begin
               rem_d = shift_s[DIVISOR_W-1:0];
               dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
            end else begin
               rem_d = diff_s[DIVISOR_W-1:0];
               dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1'b1);
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
               quotient_d  = dvd_d;
               remainder_d = rem_d;
               dbz_d       = 1'b0;
            end else begin
               state_d = CALC;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         dvd_q       <= {DIVIDEND_W{1'b0}};
         dvs_q       <= {DIVISOR_W{1'b0}};
         rem_q       <= {DIVISOR_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= {DIVIDEND_W{1'b0}};
         remainder_q <= {DIVISOR_W{1'b0}};
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/serial_divider.md
SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001: Parameter DIVIDEND_W, default 8, dividend and quotient width; the value 8 is the verified configuration.
REQ-002: Parameter DIVISOR_W, default 4, divisor and remainder width; the value 4 is the verified configuration.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: start  input  1  request; accepted only when busy=0.
REQ-006: dividend  input  DIVIDEND_W  unsigned dividend, sampled at accept.
REQ-007: divisor  input  DIVISOR_W  unsigned divisor, sampled at accept.
REQ-008: busy  output  1  high while an iteration sequence is in progress.
REQ-009: done  output  1  one-cycle pulse; results valid.
REQ-010: quotient  output  DIVIDEND_W  floor(dividend/divisor).
REQ-011: remainder  output  DIVISOR_W  dividend mod divisor.
REQ-012: div_by_zero  output  1  high with done when the sampled divisor was 0; held with the results.

Function
REQ-013: Operation: unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-014: Datapath: partial remainder is DIVISOR_W+1 bits; each iteration shifts in the next dividend bit, trial-subtracts the latched divisor, keeps the difference if it is non-negative, and sets the quotient bit to 1 in that case.
REQ-015: FSM: two states, IDLE and CALC, with an iteration counter of ceil(log2(DIVIDEND_W)) bits.
REQ-016: IDLE to CALC: at the edge where start=1, busy=0 and divisor!=0; dividend and divisor are latched, the counter is cleared, and busy=1 from that edge.
REQ-017: CALC: exactly DIVIDEND_W iterations, one per edge; at the DIVIDEND_W-th edge after accept the FSM returns to IDLE, busy=0, done=1, and quotient and remainder are updated.
REQ-018: Latency: start accepted at edge k results in done=1 in the cycle following edge k+DIVIDEND_W (k+8 by default).
REQ-019: done is high for exactly one cycle per accepted start.
REQ-020: quotient, remainder and div_by_zero hold their values after done until the next done or rst.
REQ-021: Outputs are not updated while busy=1; intermediate state is internal only.
REQ-022: start while busy=1 is ignored, with no queuing and no effect on the current operation.
REQ-023: Input changes on dividend or divisor after accept have no effect on the operation in progress.
REQ-024: start=1 in the done cycle (FSM in IDLE) is accepted, giving back-to-back operation with no dead cycle.
REQ-025: Divide by zero: start accepted with divisor=0 leaves the FSM in IDLE and busy=0; done=1 the next cycle with quotient=all ones, remainder=all ones, div_by_zero=1.
REQ-026: div_by_zero=0 on every done of a nonzero-divisor operation.
REQ-027: A held start stays asserted and restarts the operation on every idle edge; each accepted start yields exactly one done.

Reset
REQ-028: rst=1 at a rising edge forces IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and the counter and internal registers cleared.
REQ-029: rst takes priority over start in the same cycle; start is not accepted.
REQ-030: rst mid-operation aborts the operation with no done pulse; the first start after rst deasserts is accepted normally.

Verification
REQ-031: dividend=143, divisor=11, start pulse -> done 8 cycles after accept with quotient=13, remainder=0, div_by_zero=0; busy high for exactly 8 cycles.
REQ-032: Back-to-back operations, 200/7 then start held in the done cycle with 255/15 -> first done gives 28 r 4, second done 8 cycles later gives 17 r 0.
REQ-033: dividend=5, divisor=9, then dividend=255, divisor=1 -> quotient 0 r 5, then quotient 255 r 0.
REQ-034: dividend=100, divisor=0 -> done the cycle after accept, quotient=0xFF, remainder=0xF, div_by_zero=1, busy never high.
REQ-035: 143/11 started, start re-pulsed with 50/5 at cycle 3, rst at cycle 5 -> no done pulse, all outputs 0 after the rst edge; a subsequent 50/5 gives 10 r 0.
REQ-036: Exhaustive sweep, all 256 x 15 nonzero divisor pairs -> quotient*divisor+remainder==dividend and remainder<divisor for every pair.
